tlc_timer_sched: RTL and testbench
==================================

// Module: tlc_timer_sched
// PURPOSE
//  Timer and scheduler for the highway/farm-road traffic-light FSM. Watches the FSM light outputs,
//  restarts an interval counter on every light change, and drives the FSM's TS/TL inputs.
//  Folds a debounced farm-road car sensor into TL so the highway keeps green until a farm car waits.
//  Sits beside the FSM: FSM outputs -> this block -> FSM TS/TL inputs.
// PARAMETERS
//  T_SHORT  5   cycles of a short interval (yellow phase)
//  T_LONG   25  cycles of a long interval (min green phase); T_LONG > T_SHORT >= 1
//  CNT_W    8   interval counter width; 2**CNT_W > T_LONG
//  DEB_CYC  3   consecutive equal sensor samples needed to change car_present; >= 1
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  HG,HY,FG,FY  in   1 each FSM light outputs (highway/farm green/yellow)
//  car_i        in   1      raw farm-road car sensor, already synchronised to clk
//  TS           out  1      short interval elapsed
//  TL           out  1      long interval elapsed, qualified by car logic
//  ST           out  1      one-cycle pulse: timer restarted
//  car_present  out  1      debounced sensor
//  car_req      out  1      latched farm-road request
//  err          out  1      sticky illegal-light-combination flag
// BEHAVIOUR
//  - Reset (rst=1 at an edge): cnt=0, lights_q=4'b0, ST=0, car_present=0, deb_cnt=0, car_req=0, err=0.
//    So TS=0. TL=0 except FG=1 during reset: TL=~car_present=1.
//  - change = ({HG,HY,FG,FY} != lights_q), combinational. Every edge: lights_q <= {HG,HY,FG,FY}; ST <= change.
//  - Counter, per edge:
//    - change -> cnt<=0
//    - else if cnt<T_LONG -> cnt<=cnt+1
//    - else hold; cnt saturates at T_LONG, never wraps.
//  - TS_raw = (cnt>=T_SHORT); TL_raw = (cnt>=T_LONG), both from the register. TS = TS_raw.
//  - Latency: change seen in cycle k -> ST=1 and cnt=0 in cycle k+1.
//    TS rises in cycle k+1+T_SHORT; TL_raw rises in cycle k+1+T_LONG.
//  - After reset lights_q=0, so any lit FSM output restarts the timer on the first cycle (intended).
//  - Debounce:
//    - car_i==car_present -> deb_cnt<=0.
//    - Otherwise deb_cnt increments; when it would reach DEB_CYC: car_present<=car_i, deb_cnt<=0.
//    - Symmetric for rise and fall. Glitches shorter than DEB_CYC cycles are ignored.
//  - car_req, per edge: (FG|FY) -> 0 (clear wins); else if HG & car_present -> 1; else hold.
//  - TL (combinational from current inputs and registers):
//    - HG & ~FG -> TL_raw & car_req
//    - FG & ~HG -> TL_raw | ~car_present (farm green ends at once when the road empties)
//    - otherwise -> TL_raw
//  - err <= err | ((HG|HY)&(FG|FY)); cleared only by rst. Timer/TL rules above still apply when err=1.
//  - rst mid-interval: all state returns to reset values at that edge; no pending request survives.
//  - car_i toggling while HY: debounce continues; car_req is not set (HG required).
// TESTING
//  1 Reset, hold HG=1, car_i=0 for 40 cycles -> ST pulses in cycle 1 only; TS=1 from cycle 1+T_SHORT; TL stays 0; car_req=0.
//  2 HG=1, cnt saturated, car_i=1 from cycle c -> car_present=1 at c+3; car_req=1 at c+4; TL=1 same cycle as car_req.
//  3 Step HG->HY at cycle k -> ST=1 at k+1, cnt=0; TS=1 exactly at k+6 (T_SHORT=5); step HY->FG clears car_req next edge.
//  4 FG=1, car_i=1 held, then car_i=0 at cycle m with cnt<T_LONG -> TL=0 until m+2, TL=1 from m+3 (car_present falls).
//  5 car_i pulses high for 2 cycles then low (DEB_CYC=3) -> car_present stays 0, car_req stays 0.
//  6 Drive HG=1 and FG=1 together for one cycle -> err=1 next cycle and stays 1; rst -> err=0, cnt=0, TS=0.

Source files
------------

// File: rtl/tlc_timer_sched.sv
// Interval timer and farm-road car scheduler for the traffic-light FSM.
// Restarts on every light change and turns the interval count plus debounced sensor into TS/TL.
module tlc_timer_sched #(
  parameter int T_SHORT = 5,
  parameter int T_LONG  = 25,
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic HG,
  input  logic HY,
  input  logic FG,
  input  logic FY,
  input  logic car_i,
  output logic TS,
  output logic TL,
  output logic ST,
  output logic car_present,
  output logic car_req,
  output logic err
);

  localparam int                 DEB_W    = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam logic [CNT_W-1:0]   SHORT_C  = CNT_W'(T_SHORT);
  localparam logic [CNT_W-1:0]   LONG_C   = CNT_W'(T_LONG);
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [3:0]       lights;
  logic [3:0]       lights_q;
  logic             change;
  logic [CNT_W-1:0] cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic             ts_raw;
  logic             tl_raw;
  logic             conflict;

  assign lights   = {HG, HY, FG, FY};
  assign change   = (lights != lights_q);
  assign ts_raw   = (cnt >= SHORT_C);
  assign tl_raw   = (cnt >= LONG_C);
  assign conflict = (HG | HY) & (FG | FY);
  assign TS       = ts_raw;

  // Interval timer: restart on any light change, saturate at the long interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      lights_q <= 4'b0;
      ST       <= 1'b0;
      cnt      <= '0;
    end else begin
      lights_q <= lights;
      ST       <= change;
      if (change)
        cnt <= '0;
      else if (cnt < LONG_C)
        cnt <= cnt + 1'b1;
    end
  end

  // Sensor debounce: car_present follows car_i only after DEB_CYC consecutive
  // differing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      car_present <= 1'b0;
      deb_cnt     <= '0;
    end else if (car_i == car_present) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      car_present <= car_i;
      deb_cnt     <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Farm-road request is only raised while the highway is green, dropped once farm side runs.
  always_ff @(posedge clk) begin
    if (rst)
      car_req <= 1'b0;
    else if (FG | FY)
      car_req <= 1'b0;
    else if (HG & car_present)
      car_req <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else
      err <= err | conflict;
  end

  // Highway green waits for a request; farm green ends early once the road empties.
  always_comb begin
    TL = tl_raw;
    if (HG & ~FG)
      TL = tl_raw & car_req;
    else if (FG & ~HG)
      TL = tl_raw | ~car_present;
  end

endmodule

// File: tb/tb_tlc_timer_sched.sv
// Directed bench for tlc_timer_sched: table of multi-cycle steps plus a per-cycle reset sequence.
module tb_tlc_timer_sched;

  logic clk = 1'b0;
  logic rst, HG, HY, FG, FY, car_i;
  logic TS, TL, ST, car_present, car_req, err;

  int checks = 0;
  int errors = 0;

  tlc_timer_sched #(.T_SHORT(5), .T_LONG(25), .CNT_W(8), .DEB_CYC(3)) dut (
    .clk(clk), .rst(rst), .HG(HG), .HY(HY), .FG(FG), .FY(FY), .car_i(car_i),
    .TS(TS), .TL(TL), .ST(ST), .car_present(car_present), .car_req(car_req), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, hg, hy, fg, fy, car;
    int   n;
    logic ts, tl, st, cp, req, er;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(input logic r, hg, hy, fg, fy, car, input int n,
                              input logic ts, tl, st, cp, req, er);
    vec_t v;
    v.rst = r; v.hg = hg; v.hy = hy; v.fg = fg; v.fy = fy; v.car = car; v.n = n;
    v.ts = ts; v.tl = tl; v.st = st; v.cp = cp; v.req = req; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, hg, hy, fg, fy, car);
    rst = r; HG = hg; HY = hy; FG = fg; FY = fy; car_i = car;
  endtask

  initial begin
    //              rst hg hy fg fy car  n   ts tl st cp req err
    tbl[0]  = mk(1, 0,0,0,0, 0,  1,  0,0,0,0,0,0);
    tbl[1]  = mk(0, 1,0,0,0, 0,  1,  0,0,1,0,0,0);  // first lit output restarts timer
    tbl[2]  = mk(0, 1,0,0,0, 0,  4,  0,0,0,0,0,0);
    tbl[3]  = mk(0, 1,0,0,0, 0,  1,  1,0,0,0,0,0);  // cnt=5
    tbl[4]  = mk(0, 1,0,0,0, 0, 25,  1,0,0,0,0,0);  // saturated, no car -> TL held 0
    tbl[5]  = mk(0, 1,0,0,0, 1,  2,  1,0,0,0,0,0);
    tbl[6]  = mk(0, 1,0,0,0, 1,  1,  1,0,0,1,0,0);  // car_present after 3 samples
    tbl[7]  = mk(0, 1,0,0,0, 1,  1,  1,1,0,1,1,0);  // car_req, TL together
    tbl[8]  = mk(0, 0,1,0,0, 1,  1,  0,0,1,1,1,0);  // HG->HY
    tbl[9]  = mk(0, 0,1,0,0, 1,  4,  0,0,0,1,1,0);
    tbl[10] = mk(0, 0,1,0,0, 1,  1,  1,0,0,1,1,0);  // TS at k+6
    tbl[11] = mk(0, 0,0,1,0, 1,  1,  0,0,1,1,0,0);  // FG clears car_req
    tbl[12] = mk(0, 0,0,1,0, 1,  3,  0,0,0,1,0,0);
    tbl[13] = mk(0, 0,0,1,0, 0,  2,  1,0,0,1,0,0);
    tbl[14] = mk(0, 0,0,1,0, 0,  1,  1,1,0,0,0,0);  // road empty -> TL early
    tbl[15] = mk(0, 0,0,1,0, 1,  2,  1,1,0,0,0,0);  // 2-cycle glitch
    tbl[16] = mk(0, 0,0,1,0, 0,  3,  1,1,0,0,0,0);
    tbl[17] = mk(0, 1,0,0,0, 0,  1,  0,0,1,0,0,0);
    tbl[18] = mk(0, 1,0,0,0, 1,  2,  0,0,0,0,0,0);  // glitch under HG
    tbl[19] = mk(0, 1,0,0,0, 0,  3,  1,0,0,0,0,0);
    tbl[20] = mk(0, 1,0,1,0, 0,  1,  0,0,1,0,0,1);  // illegal combination
    tbl[21] = mk(0, 1,0,0,0, 0,  3,  0,0,0,0,0,1);  // err sticky
    tbl[22] = mk(1, 1,0,0,0, 0,  1,  0,0,0,0,0,0);
    tbl[23] = mk(0, 1,0,0,0, 0,  1,  0,0,1,0,0,0);
    tbl[24] = mk(1, 0,0,1,0, 0,  1,  0,1,0,0,0,0);  // FG in reset -> TL=~car_present
    tbl[25] = mk(0, 0,0,0,1, 0,  1,  0,0,1,0,0,0);
    tbl[26] = mk(0, 0,0,0,1, 0, 30,  1,1,0,0,0,0);
    tbl[27] = mk(0, 0,0,0,1, 0,  1,  1,1,0,0,0,0);  // no wrap
    tbl[28] = mk(1, 1,0,0,0, 1,  1,  0,0,0,0,0,0);
    tbl[29] = mk(0, 1,0,0,0, 1,  3,  0,0,0,1,0,0);
    tbl[30] = mk(0, 1,0,0,0, 1,  1,  0,0,0,1,1,0);
    tbl[31] = mk(1, 1,0,0,0, 1,  1,  0,0,0,0,0,0);  // pending request dropped
    tbl[32] = mk(0, 0,1,0,0, 1,  4,  0,0,0,1,0,0);  // HY never sets car_req

    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].rst, tbl[i].hg, tbl[i].hy, tbl[i].fg, tbl[i].fy, tbl[i].car);
      for (int c = 0; c < tbl[i].n; c++) begin
        @(posedge clk); #1;
      end
      chk("TS", i, TS, tbl[i].ts);
      chk("TL", i, TL, tbl[i].tl);
      chk("ST", i, ST, tbl[i].st);
      chk("car_present", i, car_present, tbl[i].cp);
      chk("car_req", i, car_req, tbl[i].req);
      chk("err", i, err, tbl[i].er);
    end

    // Per-cycle view of reset followed by steady highway green with no car.
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_ST", 0, ST, 1'b0);
    chk("rst_TS", 0, TS, 1'b0);
    chk("rst_err", 0, err, 1'b0);
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      chk("seq_ST", k, ST, (k == 1));
      chk("seq_TS", k, TS, (k >= 6));
      chk("seq_TL", k, TL, 1'b0);
      chk("seq_car_req", k, car_req, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
